// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-ported RAM between a CPU and a display/debug reader.
//   The CPU has priority. A display read is served as soon as the CPU leaves
//   a cycle free. If the CPU keeps the port busy for STARVE_LIMIT cycles in a
//   row, the CPU is stalled for one cycle so that the display read goes through.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   cpu_*           : CPU access (req, rw, type, sel, addr, wdata) ; cpu_rdata, cpu_stall
//   dsp_req/addr    : display read request (level) and word address
//   dsp_gnt         : display owns the RAM port this cycle
//   dsp_valid       : one-cycle pulse when dsp_rdata has been updated
//   dsp_rdata       : captured display read data
//   stall_count     : saturating count of forced CPU stall cycles
//   ram_*           : RAM port (combinational read data on ram_data_out)
module ram_arbiter #(
  parameter int ADDR_BITS    = 12,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_rw,
  input  logic                 cpu_type,
  input  logic [3:0]           cpu_sel,
  input  logic [ADDR_BITS-3:0] cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_stall,
  input  logic                 dsp_req,
  input  logic [ADDR_BITS-3:0] dsp_addr,
  output logic                 dsp_gnt,
  output logic                 dsp_valid,
  output logic [31:0]          dsp_rdata,
  output logic [31:0]          stall_count,
  output logic                 ram_rw,
  output logic                 ram_type,
  output logic [3:0]           ram_sel,
  output logic [ADDR_BITS-3:0] ram_addr,
  output logic [31:0]          ram_data_in,
  input  logic [31:0]          ram_data_out
);

  localparam int CW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, FORCE, DONE} state_t;

  state_t                 state, state_d;
  logic [CW-1:0]          wait_cnt;
  logic [ADDR_BITS-3:0]   pend_addr;
  logic [31:0]            rdata_q;
  logic [31:0]            stall_cnt_q;
  logic                   grant, force_stall, done;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Next state and arbitration decision. Outputs are masked during reset so
  // a request in flight never shows a grant or a stall while rst is high.
  always_comb begin
    state_d     = state;
    grant       = 1'b0;
    force_stall = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: if (dsp_req) state_d = WAIT;
      WAIT: begin
        if (!cpu_req) begin
          grant   = 1'b1;
          state_d = DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_d = FORCE;
        end
      end
      FORCE: begin
        grant       = 1'b1;
        force_stall = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      grant       = 1'b0;
      force_stall = 1'b0;
      done        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      pend_addr   <= '0;
      rdata_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && dsp_req) begin
        pend_addr <= dsp_addr;
        wait_cnt  <= '0;
      end
      if (state == WAIT && cpu_req) wait_cnt <= wait_cnt + CW'(1);
      if (grant) rdata_q <= ram_data_out;
      if (force_stall) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  // RAM port mux: the CPU drives the port combinationally unless the display
  // holds the grant, in which case a plain full-word read is issued.
  always_comb begin
    ram_rw      = cpu_req & cpu_rw;
    ram_type    = cpu_type;
    ram_sel     = cpu_sel;
    ram_addr    = cpu_addr;
    ram_data_in = cpu_wdata;
    if (grant) begin
      ram_rw      = 1'b0;
      ram_type    = 1'b0;
      ram_sel     = 4'hF;
      ram_addr    = pend_addr;
      ram_data_in = '0;
    end
  end

  assign cpu_rdata   = ram_data_out;
  assign cpu_stall   = force_stall;
  assign dsp_gnt     = grant;
  assign dsp_valid   = done;
  assign dsp_rdata   = rdata_q;
  assign stall_count = stall_cnt_q;

endmodule
